// File: rtl/i2c_sram_bridge.sv
// I2C slave bridge to an 8-bit SRAM: device-address match, 1/2-byte pointer, burst write, sequential read.
// Bus events are seen 3 clocks after the pads. SDA updates 1 clock after the scl fall. No backpressure: the master paces every bit.
module i2c_sram_bridge #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ADDR_BYTES = 1,
  parameter int         DEPTH      = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic scl,
  input  logic sda_in,
  output logic sda_oe,
  output logic busy,
  output logic wr_strobe
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    hi_q, hi_d;
  logic          ptr_idx_q, ptr_idx_d;
  logic          rw_q, rw_d;
  logic          ld_q, ld_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          mem_we;
  logic [7:0]    mem_q [DEPTH];

  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    rx_byte, rd_byte;
  logic [15:0]   ptr_full;
  logic [PW-1:0] ptr_inc;

  assign scl_sync_d = {scl_sync_q[1:0], scl};
  assign sda_sync_d = {sda_sync_q[1:0], sda_in};
  assign scl_rise   =  scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall   = ~scl_sync_q[1] &  scl_sync_q[2];
  assign start_det  =  scl_sync_q[1] & scl_sync_q[2] &  sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det   =  scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] &  sda_sync_q[1];

  assign rx_byte  = {shift_q, sda_sync_q[1]};
  assign rd_byte  = mem_q[ptr_q];
  assign ptr_full = (ADDR_BYTES == 2) ? {hi_q, rx_byte} : {8'h00, rx_byte};
  assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    hi_d        = hi_q;
    ptr_idx_d   = ptr_idx_q;
    rw_d        = rw_q;
    ld_d        = 1'b0;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    mem_we      = 1'b0;
    if (!ce || stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      ptr_idx_d = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR, PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == DEV_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = DEV_ACK;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                state_d = PTR_ACK;
                if (ADDR_BYTES == 2 && !ptr_idx_q) begin
                  hi_d      = rx_byte;
                  ptr_idx_d = 1'b1;
                end else begin
                  ptr_d     = ptr_full[PW-1:0];
                  ptr_idx_d = 1'b0;
                end
              end else begin
                state_d     = WR_ACK;
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                ptr_d       = ptr_inc;
              end
            end
          end
        end
        // First fall in an ACK state pulls SDA low, the second one releases it and moves on.
        DEV_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (state_q == DEV_ACK) busy_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == DEV_ACK) begin
                state_d = rw_q ? RD_DATA : PTR;
                ld_d    = rw_q;
              end else if (state_q == PTR_ACK) begin
                state_d = ptr_idx_q ? PTR : WR_DATA;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (ld_q) begin
            shift_d   = rd_byte[6:0];
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              state_d  = RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              shift_d   = {shift_q[5:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        // Only an ACKed slot ever reaches the scl fall here; a NACK leaves on the rise.
        RD_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (sda_sync_q[1]) state_d = WAIT_STOP;
          end else if (scl_fall) begin
            state_d = RD_DATA;
            ld_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      hi_q        <= '0;
      ptr_idx_q   <= 1'b0;
      rw_q        <= 1'b0;
      ld_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      hi_q        <= hi_d;
      ptr_idx_q   <= ptr_idx_d;
      rw_q        <= rw_d;
      ld_q        <= ld_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  // Storage is deliberately outside reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem_q[ptr_q] <= rx_byte;
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
endmodule

// File: tb/tb_i2c_sram_bridge.sv
// Directed bench: bit-banged I2C master driving a default bridge and a 2-byte-pointer, 1024-deep bridge on one bus.
module tb_i2c_sram_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b1;
  logic ce2   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic oe1, busy1, ws1, oe2, busy2, ws2;
  logic sda_line;
  int   n_chk = 0, n_fail = 0;
  int   ws_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  assign sda_line = sda_m & ~oe1 & ~oe2;

  always #5 clock = ~clock;

  i2c_sram_bridge dut (
    .clock(clock), .reset(reset), .ce(ce), .scl(scl_m), .sda_in(sda_line),
    .sda_oe(oe1), .busy(busy1), .wr_strobe(ws1)
  );

  i2c_sram_bridge #(.SLAVE_ADDR(7'h52), .ADDR_BYTES(2), .DEPTH(1024)) dut2 (
    .clock(clock), .reset(reset), .ce(ce2), .scl(scl_m), .sda_in(sda_line),
    .sda_oe(oe2), .busy(busy2), .wr_strobe(ws2)
  );

  always @(negedge clock) begin
    if (ws1 | ws2)     ws_cnt   <= ws_cnt + 1;
    if (oe1)           oe_cnt   <= oe_cnt + 1;
    if (busy1 | busy2) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bitx(input logic b, output logic r);
    sda_m = b;
    tick(8);
    scl_m = 1'b1;
    tick(4);
    r = sda_line;
    tick(4);
    scl_m = 1'b0;
    tick(8);
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(8);
    scl_m = 1'b1; tick(8);
    sda_m = 1'b0; tick(8);
    scl_m = 1'b0; tick(8);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(8);
    scl_m = 1'b1; tick(8);
    sda_m = 1'b1; tick(8);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(d[i], r);
    bitx(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, r);
      d[i] = r;
    end
    bitx(nack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         w0, o0, b0;

    tick(4);
    chk("reset sda_oe", 32'(oe1), 32'd0);
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset wr_strobe", 32'(ws1), 32'd0);
    chk("reset ptr", 32'(dut.ptr_q), 32'd0);
    reset = 1'b1;
    tick(4);

    // Burst write of three bytes from 0x10
    w0 = ws_cnt;
    start_c();
    wr_byte(8'hA0, ack); chk("wr addr ack", 32'(ack), 32'd1);
    chk("busy after addr ack", 32'(busy1), 32'd1);
    wr_byte(8'h10, ack); chk("wr ptr ack", 32'(ack), 32'd1);
    wr_byte(8'h11, ack); chk("wr d0 ack", 32'(ack), 32'd1);
    wr_byte(8'h22, ack); chk("wr d1 ack", 32'(ack), 32'd1);
    wr_byte(8'h33, ack); chk("wr d2 ack", 32'(ack), 32'd1);
    stop_c();
    chk("wr strobe count", 32'(ws_cnt - w0), 32'd3);
    chk("busy after stop", 32'(busy1), 32'd0);
    chk("ptr after write", 32'(dut.ptr_q), 32'h13);

    // Random read via repeated START
    start_c();
    wr_byte(8'hA0, ack);
    wr_byte(8'h10, ack);
    start_c();
    wr_byte(8'hA1, ack); chk("rd addr ack", 32'(ack), 32'd1);
    rd_byte(1'b0, d); chk("rd byte0", 32'(d), 32'h11);
    rd_byte(1'b0, d); chk("rd byte1", 32'(d), 32'h22);
    rd_byte(1'b1, d); chk("rd byte2", 32'(d), 32'h33);
    chk("ptr after read", 32'(dut.ptr_q), 32'h13);
    chk("sda released after nack", 32'(oe1), 32'd0);
    stop_c();

    // Foreign address is ignored, then a normal transaction still works
    o0 = oe_cnt; b0 = busy_cnt;
    start_c();
    wr_byte(8'hA2, ack); chk("wrong addr no ack", 32'(ack), 32'd0);
    wr_byte(8'h00, ack); chk("wrong addr data no ack", 32'(ack), 32'd0);
    chk("wrong addr sda_oe quiet", 32'(oe_cnt - o0), 32'd0);
    chk("wrong addr busy quiet", 32'(busy_cnt - b0), 32'd0);
    stop_c();
    start_c();
    wr_byte(8'hA0, ack); chk("post-wrong addr ack", 32'(ack), 32'd1);
    wr_byte(8'h12, ack);
    start_c();
    wr_byte(8'hA1, ack);
    rd_byte(1'b1, d); chk("post-wrong read", 32'(d), 32'h33);
    stop_c();

    // Pointer wrap at DEPTH-1
    start_c();
    wr_byte(8'hA0, ack);
    wr_byte(8'hFF, ack);
    wr_byte(8'h5A, ack); chk("wrap d0 ack", 32'(ack), 32'd1);
    wr_byte(8'hA5, ack); chk("wrap d1 ack", 32'(ack), 32'd1);
    stop_c();
    chk("ptr after wrap write", 32'(dut.ptr_q), 32'h01);
    start_c();
    wr_byte(8'hA0, ack);
    wr_byte(8'hFF, ack);
    start_c();
    wr_byte(8'hA1, ack);
    rd_byte(1'b0, d); chk("wrap rd0", 32'(d), 32'h5A);
    rd_byte(1'b1, d); chk("wrap rd1", 32'(d), 32'hA5);
    stop_c();

    // Two-byte pointer on the 1024-deep instance
    start_c();
    wr_byte(8'hA4, ack); chk("2b addr ack", 32'(ack), 32'd1);
    wr_byte(8'h83, ack); chk("2b ptr hi ack", 32'(ack), 32'd1);
    wr_byte(8'h20, ack); chk("2b ptr lo ack", 32'(ack), 32'd1);
    wr_byte(8'h77, ack); chk("2b data ack", 32'(ack), 32'd1);
    stop_c();
    chk("2b mem[0x320]", 32'(dut2.mem_q[10'h320]), 32'h77);
    chk("2b ptr", 32'(dut2.ptr_q), 32'h321);
    start_c();
    wr_byte(8'hA4, ack);
    wr_byte(8'h83, ack);
    wr_byte(8'h20, ack);
    start_c();
    wr_byte(8'hA5, ack);
    rd_byte(1'b1, d); chk("2b readback", 32'(d), 32'h77);
    stop_c();

    // ce dropped halfway through a data byte
    start_c();
    wr_byte(8'hA0, ack);
    wr_byte(8'h40, ack);
    for (int i = 0; i < 4; i++) bitx(1'b1, r);
    chk("busy before ce drop", 32'(busy1), 32'd1);
    w0 = ws_cnt;
    ce = 1'b0;
    tick(1);
    chk("ce drop busy", 32'(busy1), 32'd0);
    chk("ce drop sda_oe", 32'(oe1), 32'd0);
    for (int i = 0; i < 4; i++) bitx(1'b0, r);
    bitx(1'b1, r); chk("ce drop no ack", 32'(r), 32'd1);
    chk("ce drop no strobe", 32'(ws_cnt - w0), 32'd0);
    ce = 1'b1;
    stop_c();

    // Reset asserted while a read bit is being driven low
    start_c();
    wr_byte(8'hA0, ack);
    wr_byte(8'h10, ack);
    start_c();
    wr_byte(8'hA1, ack);
    bitx(1'b1, r);
    bitx(1'b1, r);
    chk("read drives zero bit", 32'(oe1), 32'd1);
    chk("busy during read", 32'(busy1), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("rst sda_oe", 32'(oe1), 32'd0);
    chk("rst busy", 32'(busy1), 32'd0);
    chk("rst wr_strobe", 32'(ws1), 32'd0);
    chk("rst ptr", 32'(dut.ptr_q), 32'd0);
    reset = 1'b1;
    stop_c();
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
